// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS execute stage and the ALU
// control decoder.
//   * ALU_*   : 3-bit ALU operation codes driven on aluCntrl.
//   * ST_*    : states of the iterative multiplier FSM (mul_state_t).
package mips_pkg;

  // ALU operation codes; any code not listed here executes as ADD.
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;

  // Multiplier FSM state encoding, kept as plain constants so older code
  // that compares against raw 2-bit values keeps working.
  typedef logic [1:0] mul_state_t;
  localparam mul_state_t ST_IDLE = 2'b00;
  localparam mul_state_t ST_BUSY = 2'b01;
  localparam mul_state_t ST_DONE = 2'b10;

endpackage

// File: rtl/mul_iter.sv
// mul_iter -- iterative shift-add multiplier, one multiplier bit per cycle.
// Produces the low WIDTH bits of a*b, which are the same for signed and
// unsigned operands. Always runs the full WIDTH steps (no early exit).
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset, aborts an in-flight multiply
//   start   : accepted only in IDLE; latches a/b and clears acc/counter
//   a, b    : operands (sampled on the start cycle only)
//   busy    : high for the WIDTH shift-add cycles
//   done    : high for the single cycle after the last step
//   product : accumulator contents (final product while done is high)
module mul_iter
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  mul_state_t       state_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;

  // FSM plus shift-add datapath: one multiplier bit consumed per BUSY cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            state_r  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_DONE;
          end
        end
        // DONE always returns to IDLE, so a still-presented MUL cannot
        // restart from here.
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_r == ST_BUSY);
  assign done    = (state_r == ST_DONE);
  assign product = acc_r;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- MIPS EX-stage ALU.
// ADD/SUB/SLT are combinational (zero latency, no stall). MUL is handed to
// the iterative multiplier: stall is raised combinationally in the issue
// cycle and held through BUSY (WIDTH+1 cycles total); the product appears
// in the following (DONE) cycle with stall low.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   valid_in   : EX stage holds a valid instruction
//   aluCntrl   : operation code (see mips_pkg)
//   srcA, srcB : operands
//   result     : operation result
//   zero       : result == 0 (branch decisions)
//   stall      : freeze PC and upstream registers
module alu_exec_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [2:0]       aluCntrl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             stall
);

  logic             mul_busy_s;
  logic             mul_done_s;
  logic             mul_idle_s;
  logic             mul_issue_s;
  logic [WIDTH-1:0] mul_product_s;
  logic [WIDTH-1:0] alu_s;
  logic             slt_s;

  assign mul_idle_s  = !mul_busy_s && !mul_done_s;
  assign mul_issue_s = valid_in && (aluCntrl == ALU_MUL) && mul_idle_s;

  mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_issue_s),
    .a       (srcA),
    .b       (srcB),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  assign slt_s = ($signed(srcA) < $signed(srcB));

  // Combinational op mux; unknown codes fall back to ADD.
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (aluCntrl)
      ALU_ADD: alu_s = srcA + srcB;
      ALU_SUB: alu_s = srcA - srcB;
      ALU_SLT: alu_s = {{(WIDTH-1){1'b0}}, slt_s};
      ALU_MUL: alu_s = mul_product_s;
      default: alu_s = srcA + srcB;
    endcase
  end

  // In DONE the accumulator wins regardless of what is on the inputs.
  always_comb begin
    result = {WIDTH{1'b0}};
    if (mul_done_s) begin
      result = mul_product_s;
    end else begin
      result = alu_s;
    end
  end

  assign zero  = (result == {WIDTH{1'b0}});
  assign stall = mul_issue_s || mul_busy_s;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit -- directed self-checking bench for alu_exec_unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge.
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             valid_in;
  logic [2:0]       aluCntrl;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             stall;

  int tests_run;
  int tests_failed;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .aluCntrl (aluCntrl),
    .srcA     (srcA),
    .srcB     (srcB),
    .result   (result),
    .zero     (zero),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    valid_in = v;
    aluCntrl = op;
    srcA     = a;
    srcB     = b;
  endtask

  // Runs a MUL from the current (IDLE) point: counts stall cycles and
  // returns the result/zero seen in the first non-stalled cycle.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit toggle, output int n_stall,
                         output logic [WIDTH-1:0] res, output logic z);
    n_stall = 0;
    drive(1'b1, 3'b101, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      n_stall++;
      if (toggle) begin
        @(posedge clk); #1;
        drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom, $urandom);
      end else begin
        @(posedge clk); #1;
      end
    end
    res = result;
    z   = zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 3'b010, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset: stall=%0b result=%h zero=%0b, want 0/00000000/1",
               stall, result, zero);
    end
  endtask

  task automatic test_add();
    @(posedge clk); #1;
    drive(1'b1, 3'b010, 32'd7, 32'd5);
    #1;
    tests_run++;
    if (result !== 32'd12 || zero !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_7_5: result=%h zero=%0b stall=%0b, want 0000000c/0/0",
               result, zero, stall);
    end
    drive(1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1);
    #1;
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_wrap: result=%h zero=%0b, want 00000000/1", result, zero);
    end
    drive(1'b1, 3'b000, 32'd100, 32'd23);
    #1;
    tests_run++;
    if (result !== 32'd123 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_default_code: result=%h stall=%0b, want 0000007b/0",
               result, stall);
    end
    drive(1'b1, 3'b111, 32'h8000_0000, 32'h8000_0001);
    #1;
    tests_run++;
    if (result !== 32'd1) begin
      tests_failed++;
      $display("FAIL add_code111: result=%h, want 00000001", result);
    end
    drive(1'b0, 3'b010, 32'd40, 32'd2);
    @(negedge clk);
    tests_run++;
    if (result !== 32'd42 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_invalid: result=%h stall=%0b, want 0000002a/0",
               result, stall);
    end
  endtask

  task automatic test_sub();
    @(posedge clk); #1;
    drive(1'b1, 3'b100, 32'h1234, 32'h1234);
    #1;
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_equal: result=%h zero=%0b stall=%0b, want 00000000/1/0",
               result, zero, stall);
    end
    drive(1'b1, 3'b100, 32'd0, 32'd1);
    #1;
    tests_run++;
    if (result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_wrap: result=%h zero=%0b, want ffffffff/0", result, zero);
    end
    drive(1'b1, 3'b100, 32'd50, 32'd8);
    #1;
    tests_run++;
    if (result !== 32'd42) begin
      tests_failed++;
      $display("FAIL sub_50_8: result=%h, want 0000002a", result);
    end
  endtask

  task automatic test_slt();
    @(posedge clk); #1;
    drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1);
    #1;
    tests_run++;
    if (result !== 32'd1 || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL slt_neg_lt: result=%h zero=%0b, want 00000001/0", result, zero);
    end
    drive(1'b1, 3'b110, 32'd1, 32'hFFFF_FFFF);
    #1;
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL slt_swapped: result=%h zero=%0b, want 00000000/1", result, zero);
    end
    drive(1'b1, 3'b110, 32'd5, 32'd5);
    #1;
    tests_run++;
    if (result !== 32'd0) begin
      tests_failed++;
      $display("FAIL slt_equal: result=%h, want 00000000", result);
    end
  endtask

  task automatic test_mul_basic();
    int n; logic [WIDTH-1:0] r; logic z;
    @(posedge clk); #1;
    run_mul(32'd6, 32'd7, 1'b0, n, r, z);
    tests_run++;
    if (n !== 33) begin
      tests_failed++;
      $display("FAIL mul_stall_len: stall cycles=%0d, want 33", n);
    end
    tests_run++;
    if (r !== 32'd42 || z !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_6x7: result=%h zero=%0b stall=%0b, want 0000002a/0/0",
               r, z, stall);
    end
    // DONE -> IDLE unconditionally: the next cycle runs an ADD unstalled.
    @(posedge clk); #1;
    drive(1'b1, 3'b010, 32'd2, 32'd3);
    @(negedge clk);
    tests_run++;
    if (result !== 32'd5 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_back_to_idle: result=%h stall=%0b, want 00000005/0",
               result, stall);
    end
  endtask

  task automatic test_mul_signed();
    int n; logic [WIDTH-1:0] r; logic z;
    @(posedge clk); #1;
    run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, n, r, z);
    tests_run++;
    if (n !== 33 || r !== 32'hFFFF_FFF1) begin
      tests_failed++;
      $display("FAIL mul_signed_toggle: stalls=%0d result=%h, want 33/fffffff1",
               n, r);
    end
    @(posedge clk); #1;
    drive(1'b1, 3'b010, 32'd0, 32'd0);
  endtask

  task automatic test_mul_zero();
    int n; logic [WIDTH-1:0] r; logic z;
    @(posedge clk); #1;
    run_mul(32'd0, 32'd12345, 1'b0, n, r, z);
    tests_run++;
    if (n !== 33 || r !== 32'd0 || z !== 1'b1) begin
      tests_failed++;
      $display("FAIL mul_by_zero: stalls=%0d result=%h zero=%0b, want 33/00000000/1",
               n, r, z);
    end
    @(posedge clk); #1;
    drive(1'b1, 3'b010, 32'd0, 32'd0);
  endtask

  task automatic test_reset_mid_mul();
    @(posedge clk); #1;
    drive(1'b1, 3'b101, 32'd6, 32'd7);
    // Issue edge plus 10 BUSY steps.
    repeat (11) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_mul_busy: stall=%0b, want 1", stall);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b1, 3'b010, 32'd1, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || result !== 32'd2 || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort: stall=%0b result=%h zero=%0b, want 0/00000002/0",
               stall, result, zero);
    end
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || result !== 32'd2) begin
      tests_failed++;
      $display("FAIL reset_abort_hold: stall=%0b result=%h, want 0/00000002",
               stall, result);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive(1'b0, 3'b010, 32'd0, 32'd0);
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_mul_basic();
    test_mul_signed();
    test_mul_zero();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, 32, datapath width in bits.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  reset: synchronous, active-low.
REQ-004 The block SHALL have port valid_in  input  1  EX stage holds a valid instruction.
REQ-005 The block SHALL have port aluCntrl  input  3  operation code from the ALU control decoder.
REQ-006 The block SHALL have port srcA  input  WIDTH  first operand (rs).
REQ-007 The block SHALL have port srcB  input  WIDTH  second operand (rt or sign-extended immediate).
REQ-008 The block SHALL have port result  output  WIDTH  operation result.
REQ-009 The block SHALL have port zero  output  1  result equals 0, used for branch decisions.
REQ-010 The block SHALL have port stall  output  1  freeze PC and upstream registers; operands held stable.

Function
REQ-011 The block SHALL decode aluCntrl as follows: 010 ADD, 100 SUB, 110 SLT, 101 MUL, and any other code as ADD.
REQ-012 ADD and SUB SHALL wrap modulo 2^WIDTH; there SHALL be no overflow flag.
REQ-013 SLT SHALL perform a signed compare: result = 1 if srcA < srcB, else 0, zero-extended.
REQ-014 ADD, SUB and SLT SHALL be combinational, with zero latency; stall SHALL be 0 and result valid in the same cycle.
REQ-015 zero SHALL equal (result == 0) in every cycle and every state.
REQ-016 MUL SHALL produce the low WIDTH bits of srcA*srcB; these are identical for signed and unsigned operands.
REQ-017 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-018 IDLE -> BUSY SHALL occur when valid_in=1 and aluCntrl=101; in that cycle srcA and srcB SHALL be latched, the counter cleared and the accumulator cleared.
REQ-019 In IDLE, stall SHALL be asserted combinationally in the MUL issue cycle; otherwise stall=0.
REQ-020 In BUSY, each cycle SHALL perform one shift-add step (add the multiplicand if the LSB of the multiplier is 1, shift the multiplicand left, shift the multiplier right) and increment the 5-bit counter (log2(WIDTH) bits in general).
REQ-021 BUSY -> DONE SHALL occur after exactly WIDTH steps (counter = WIDTH-1 on the last step); stall=1 throughout BUSY.
REQ-022 In DONE, stall SHALL be 0 and result SHALL be the accumulator; the transition DONE -> IDLE SHALL be unconditional, and no MUL re-issue SHALL occur from DONE even though the same instruction is still presented.
REQ-023 MUL timing SHALL be: stall high for WIDTH+1 consecutive cycles (issue cycle plus BUSY), and the result SHALL appear in the following cycle.
REQ-024 Changes on srcA, srcB, aluCntrl or valid_in during BUSY SHALL be ignored.
REQ-025 In IDLE with valid_in=0, result SHALL still reflect the combinational op on the current inputs and stall SHALL be 0.
REQ-026 A MUL by 0 SHALL still take the full WIDTH steps; there SHALL be no early termination.

Reset
REQ-027 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE, and the counter, accumulator and latched operands SHALL be cleared to 0.
REQ-028 Reset SHALL override every other input and SHALL abort an in-flight MUL; stall SHALL be 0 from the cycle after that edge.
REQ-029 After reset, outputs SHALL be the combinational function of the current inputs, with stall=0.

Structure
REQ-030 The ALU opcode constants (ADD=010, SUB=100, SLT=110, MUL=101) and the FSM state type SHALL reside in the shared package mips_pkg, which is also used by the decoder.
REQ-031 The iterative multiplier (operand registers, accumulator, counter) SHALL be a sub-module mul_iter with start/busy/done/product ports; alu_exec_unit SHALL own the op mux, zero detect and stall generation.
REQ-032 The block SHALL contain no multiplier primitive; it SHALL use only the shift-add datapath.

Verification
REQ-033 ADD: srcA=7, srcB=5, aluCntrl=010 -> result=12, zero=0, stall=0 in the same cycle.
REQ-034 SUB/branch: srcA=srcB=0x1234, aluCntrl=100 -> result=0, zero=1; SUB with srcA=0, srcB=1 -> result=0xFFFFFFFF.
REQ-035 SLT signed: srcA=0xFFFFFFFF (-1), srcB=1, aluCntrl=110 -> result=1; swapped operands -> result=0.
REQ-036 MUL: srcA=6, srcB=7, valid_in=1, aluCntrl=101 -> stall=1 for exactly 33 cycles, then one cycle with stall=0 and result=42; the FSM is in IDLE on the next cycle.
REQ-037 MUL with signed operands: srcA=-3, srcB=5 -> result=0xFFFFFFF1; inputs toggled randomly during BUSY do not change the result.
REQ-038 Reset mid-MUL: rst_n=0 at BUSY step 10 -> stall=0 on the next cycle, FSM in IDLE, and a following ADD 1+1 gives result=2.
